// File: rtl/brisc_pkg.sv
// brisc_pkg: shared types and constants for the cache / main-memory interface.
//   mem_req_t   : line request from cache (valid, rw, addr, data)
//   mem_resp_t  : line response to cache (ready, addr, data)
//   mem_state_e : main_mem controller states
package brisc_pkg;

  localparam int unsigned ADDR_LEN       = 32;
  localparam int unsigned CACHE_LINE_LEN = 128;
  localparam int unsigned OFFSET_LEN     = $clog2(CACHE_LINE_LEN / 8);
  localparam int unsigned MEM_REQ_DELAY  = 5;
  localparam int unsigned MEM_RESP_DELAY = 5;
  localparam int unsigned MEM_DEPTH      = 65536;

  typedef struct packed {
    logic                      valid;
    logic                      rw;     // 1 = write
    logic [ADDR_LEN-1:0]       addr;
    logic [CACHE_LINE_LEN-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic                      ready;
    logic [ADDR_LEN-1:0]       addr;
    logic [CACHE_LINE_LEN-1:0] data;
  } mem_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ_WAIT,
    RESP_WAIT,
    RESP
  } mem_state_e;

endpackage

// File: rtl/main_mem_array.sv
// main_mem_array: synchronous single-port line RAM, one 128-bit line per entry.
//   clk     : clock
//   i_en    : access enable (one access per enabled edge)
//   i_we    : 1 = write i_wdata, 0 = read into o_rdata
//   i_idx   : line index
//   i_wdata : write line
//   o_rdata : read line, updated only by an enabled read
// Contents are never reset.
module main_mem_array
  import brisc_pkg::*;
#(
  parameter int unsigned DEPTH_LINES = MEM_DEPTH * 8 / CACHE_LINE_LEN,
  parameter string       INIT_FILE   = "",
  parameter int unsigned IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic                      clk,
  input  logic                      i_en,
  input  logic                      i_we,
  input  logic [IDX_W-1:0]          i_idx,
  input  logic [CACHE_LINE_LEN-1:0] i_wdata,
  output logic [CACHE_LINE_LEN-1:0] o_rdata
);

  logic [CACHE_LINE_LEN-1:0] r_mem [DEPTH_LINES];
  logic [CACHE_LINE_LEN-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_idx] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/main_mem.sv
// main_mem: fixed-latency line memory behind the cache.
//   clk    : clock, all state on rising edge
//   reset  : asynchronous active-high reset
//   req_i  : line request (valid, rw, addr, data)
//   resp_o : response (ready pulse, line-aligned addr, line data)
//   busy_o : high while a request is in flight
// One request at a time: accept -> REQ_DELAY edges -> array access ->
// RESP_DELAY edges -> one-cycle ready. Requests while busy are dropped.
module main_mem
  import brisc_pkg::*;
#(
  parameter int unsigned REQ_DELAY   = MEM_REQ_DELAY,
  parameter int unsigned RESP_DELAY  = MEM_RESP_DELAY,
  parameter int unsigned DEPTH_BYTES = MEM_DEPTH,
  parameter string       INIT_FILE   = ""
) (
  input  logic      clk,
  input  logic      reset,
  input  mem_req_t  req_i,
  output mem_resp_t resp_o,
  output logic      busy_o
);

  localparam int unsigned DEPTH_LINES = DEPTH_BYTES * 8 / CACHE_LINE_LEN;
  localparam int unsigned IDX_W       = $clog2(DEPTH_LINES);
  localparam int unsigned MAX_DELAY   = (REQ_DELAY > RESP_DELAY) ? REQ_DELAY : RESP_DELAY;
  localparam int unsigned CNT_W       = $clog2(MAX_DELAY + 1);

  if (REQ_DELAY < 1 || RESP_DELAY < 1) begin : g_bad_delay
    $error("main_mem: REQ_DELAY and RESP_DELAY must be >= 1");
  end
  if ((DEPTH_BYTES % (CACHE_LINE_LEN / 8)) != 0) begin : g_bad_depth
    $error("main_mem: DEPTH_BYTES must be a whole number of lines");
  end

  mem_state_e                r_state, w_state_next;
  logic [CNT_W-1:0]          r_cnt, w_cnt_next;
  logic                      w_accept, w_access;
  logic                      r_rw;
  logic [ADDR_LEN-1:0]       r_addr;
  logic [CACHE_LINE_LEN-1:0] r_data;
  logic [ADDR_LEN-1:0]       r_resp_addr;
  logic [CACHE_LINE_LEN-1:0] r_resp_data;
  logic                      r_resp_load;  // RAM read data valid this cycle
  logic [CACHE_LINE_LEN-1:0] w_rdata;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_access     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_i.valid) begin
          w_accept     = 1'b1;
          w_cnt_next   = CNT_W'(REQ_DELAY - 1);
          w_state_next = REQ_WAIT;
        end
      end
      REQ_WAIT: begin
        if (r_cnt == '0) begin
          w_access     = 1'b1;
          w_cnt_next   = CNT_W'(RESP_DELAY - 1);
          w_state_next = RESP_WAIT;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      RESP_WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = RESP;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_resp_addr <= '0;
      r_resp_data <= '0;
      r_resp_load <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_resp_load <= w_access;
      if (w_accept) begin
        r_rw   <= req_i.rw;
        r_addr <= {req_i.addr[ADDR_LEN-1:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
        r_data <= req_i.data;
      end
      if (w_access) begin
        r_resp_addr <= r_addr;
      end
      // RAM output lands one edge after the access; writes echo the stored line.
      if (r_resp_load) begin
        r_resp_data <= r_rw ? r_data : w_rdata;
      end
    end
  end

  main_mem_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .INIT_FILE   (INIT_FILE),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_en    (w_access),
    .i_we    (r_rw),
    .i_idx   (r_addr[OFFSET_LEN +: IDX_W]),
    .i_wdata (r_data),
    .o_rdata (w_rdata)
  );

  always_comb begin
    resp_o       = '0;
    resp_o.ready = (r_state == RESP);
    resp_o.addr  = r_resp_addr;
    resp_o.data  = r_resp_data;
  end

  assign busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_main_mem.sv
// tb_main_mem: directed + randomized checks of main_mem against a line-level
// memory model (associative array keyed by line index) and fixed-latency timing.
module tb_main_mem;
  import brisc_pkg::*;

  localparam int unsigned REQ_D   = 5;
  localparam int unsigned RESP_D  = 5;
  localparam int unsigned LAT     = REQ_D + RESP_D;
  localparam int unsigned LINES   = 65536 / 16;
  localparam int unsigned NRAND   = 40;

  logic      clk;
  logic      reset;
  mem_req_t  req;
  mem_resp_t resp;
  logic      busy;

  int tests;
  int fails;

  logic [127:0] model [int unsigned];

  main_mem #(
    .REQ_DELAY   (REQ_D),
    .RESP_DELAY  (RESP_D),
    .DEPTH_BYTES (65536),
    .INIT_FILE   ("")
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req_i  (req),
    .resp_o (resp),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction. pulse_at>0: inject a write of pulse_data that many edges
  // after accept. reset_at>0: assert reset that many edges after accept.
  task automatic txn(input bit rw, input logic [31:0] addr, input logic [127:0] data,
                     input int pulse_at, input logic [127:0] pulse_data, input int reset_at);
    int           lat;
    bit           got;
    bit           aborted;
    bit           have_exp;
    bit           seen;
    logic [127:0] exp_data;
    int unsigned  idx;
    idx = (addr >> 4) % LINES;
    @(negedge clk);
    req.valid = 1'b1;
    req.rw    = rw;
    req.addr  = addr;
    req.data  = data;
    @(posedge clk);
    #1;
    req.valid = 1'b0;
    chk("busy_after_accept", 160'(busy), 160'(1));
    exp_data = '0;
    if (rw) begin
      have_exp = 1'b1;
      exp_data = data;
    end else begin
      have_exp = model.exists(idx);
      if (have_exp) exp_data = model[idx];
    end
    lat = 0;
    got = 1'b0;
    aborted = 1'b0;
    while (!got && !aborted && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (reset_at == lat) begin
        reset = 1'b1;
        #1;
        chk("reset_mid_busy", 160'(busy), 160'(0));
        chk("reset_mid_ready", 160'(resp.ready), 160'(0));
        chk("reset_mid_addr", 160'(resp.addr), 160'(0));
        chk("reset_mid_data", 160'(resp.data), 160'(0));
        @(negedge clk);
        reset = 1'b0;
        aborted = 1'b1;
      end else begin
        if (pulse_at == lat) begin
          req.valid = 1'b1;
          req.rw    = 1'b1;
          req.addr  = addr;
          req.data  = pulse_data;
        end else if (pulse_at + 1 == lat) begin
          req.valid = 1'b0;
        end
        if (resp.ready) got = 1'b1;
      end
    end
    if (aborted) begin
      seen = 1'b0;
      repeat (2 * LAT) begin
        @(posedge clk);
        #1;
        if (resp.ready) seen = 1'b1;
      end
      chk("no_resp_after_reset", 160'(seen), 160'(0));
    end else begin
      chk("latency", 160'(lat), 160'(LAT));
      chk("resp_addr", 160'(resp.addr), 160'(addr & 32'hFFFF_FFF0));
      if (have_exp) chk("resp_data", 160'(resp.data), 160'(exp_data));
      if (rw) model[idx] = data;
      @(posedge clk);
      #1;
      chk("ready_one_cycle", 160'(resp.ready), 160'(0));
      chk("idle_after_resp", 160'(busy), 160'(0));
      if (pulse_at > 0) begin
        seen = 1'b0;
        repeat (2 * LAT) begin
          @(posedge clk);
          #1;
          if (resp.ready || busy) seen = 1'b1;
        end
        chk("busy_req_ignored", 160'(seen), 160'(0));
      end
    end
  endtask

  initial begin
    logic [127:0] d1;
    logic [127:0] da;
    logic [31:0]  raddr;
    logic [127:0] rdata;
    int           pulses [$];
    int           cyc;
    bit           prev_rdy;
    bit           wide;
    bit           rrw;

    tests = 0;
    fails = 0;
    req   = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 160'(resp.ready), 160'(0));
    chk("reset_addr", 160'(resp.addr), 160'(0));
    chk("reset_data", 160'(resp.data), 160'(0));
    chk("reset_busy", 160'(busy), 160'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_req", 160'(busy), 160'(0));

    // Write then read, aligned readback of an unaligned address.
    d1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    txn(1'b1, 32'h0000_4000, d1, 0, '0, 0);
    txn(1'b0, 32'h0000_4000, '0, 0, '0, 0);
    txn(1'b0, 32'h0000_400C, '0, 0, '0, 0);

    // Address wrap beyond DEPTH_BYTES.
    da = 128'hAAAA_5555_1234_5678_9ABC_DEF0_0F1E_2D3C;
    txn(1'b1, 32'h0001_0010, da, 0, '0, 0);
    txn(1'b0, 32'h0000_0010, '0, 0, '0, 0);

    // Request while busy is ignored.
    txn(1'b1, 32'h0000_4000, 128'hC0DE_0000_1111_2222_3333_4444_5555_6666,
        3, 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB, 0);
    txn(1'b0, 32'h0000_4000, '0, 0, '0, 0);

    // Reset before the access edge must not disturb the array.
    txn(1'b1, 32'h0000_5000, 128'h5050_5050_0000_0000_FFFF_FFFF_1234_0000, 0, '0, 0);
    txn(1'b1, 32'h0000_5000, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 0, '0, 2);
    txn(1'b0, 32'h0000_5000, '0, 0, '0, 0);

    // Back-to-back with valid held high.
    @(negedge clk);
    req.valid = 1'b1;
    req.rw    = 1'b0;
    req.addr  = 32'h0000_4000;
    req.data  = '0;
    cyc = 0;
    prev_rdy = 1'b0;
    wide = 1'b0;
    repeat (60) begin
      @(posedge clk);
      cyc++;
      #1;
      if (resp.ready) begin
        pulses.push_back(cyc);
        chk("b2b_data", 160'(resp.data), 160'(model[32'h400]));
      end
      if (resp.ready && prev_rdy) wide = 1'b1;
      prev_rdy = resp.ready;
    end
    req.valid = 1'b0;
    chk("b2b_pulse_count", 160'(pulses.size()), 160'(5));
    chk("b2b_pulse_width", 160'(wide), 160'(0));
    for (int i = 1; i < pulses.size(); i++) begin
      chk("b2b_spacing", 160'(pulses[i] - pulses[i-1]), 160'(LAT + 2));
    end
    cyc = 0;
    while (busy && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("b2b_drain", 160'(busy), 160'(0));

    // Randomized traffic over a small set of lines, with aliasing high bits.
    for (int n = 0; n < NRAND; n++) begin
      rrw   = 1'($urandom_range(0, 1));
      raddr = ($urandom_range(0, 3) << 16) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
      rdata = {$urandom, $urandom, $urandom, $urandom};
      txn(rrw, raddr, rdata, 0, '0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
